// File: rtl/sort_stream_pkg.sv
// Shared state, slot type and key comparison for the streaming insertion sorter.
// Build option SORT_STREAM_SIGNED_EN selects two's-complement key comparison.
package sort_stream_pkg;

   // Slot fields are sized for the widest supported build (WIDTH <= 64, IDX_W <= 16);
   // upper bits of narrower builds stay constant zero.
   localparam int unsigned SLOT_DATA_W = 64;
   localparam int unsigned SLOT_IDX_W  = 16;

   typedef enum logic {
      LOAD,
      DRAIN
   } state_e;

   typedef struct packed {
      logic                   valid;
      logic [SLOT_DATA_W-1:0] data;
      logic [SLOT_IDX_W-1:0]  index;
   } slot_t;

   // Keys arrive left-justified, so the sample sign bit is always the MSB here.
   function automatic logic precedes(input logic [SLOT_DATA_W-1:0] a,
                                     input logic [SLOT_DATA_W-1:0] b,
                                     input logic                   descend);
`ifdef SORT_STREAM_SIGNED_EN
      if (descend) return $signed(a) >= $signed(b);
      return $signed(a) <= $signed(b);
`else
      if (descend) return a >= b;
      return a <= b;
`endif
   endfunction

endpackage

// File: rtl/sort_stream_cell.sv
// One slot of the insertion sorter: holds an entry, reports whether it precedes the
// incoming sample, and chooses hold / load-new / take-lower / take-upper.
module sort_stream_cell
   import sort_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  insert,
   input  logic  shift_down,
   input  logic  descend,
   input  slot_t new_slot,
   input  logic  lower_prec,
   input  slot_t lower_slot,
   input  slot_t upper_slot,
   output logic  prec,
   output slot_t slot
);

   localparam int unsigned Justify = SLOT_DATA_W - WIDTH;

   slot_t                  slot_q, slot_d;
   logic [SLOT_DATA_W-1:0] own_key, new_key;

   always_comb begin
      own_key = slot_q.data << Justify;
      new_key = new_slot.data << Justify;
   end

   assign prec = slot_q.valid & precedes(own_key, new_key, descend);

   // Preceding entries form a prefix, so the first non-preceding slot takes the new
   // sample and every slot above it takes its lower neighbour.
   always_comb begin
      slot_d = slot_q;
      if (insert) begin
         if (!prec) slot_d = lower_prec ? new_slot : lower_slot;
      end else if (shift_down) begin
         slot_d = upper_slot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign slot = slot_q;

endmodule

// File: rtl/sort_stream.sv
// Streaming stable insertion sorter: loads a frame of up to DEPTH samples, then drains
// it in ascending/descending order with arrival indices. Option: SORT_STREAM_SIGNED_EN.
module sort_stream
   import sort_stream_pkg::*;
#(
   parameter int unsigned DEPTH = 250,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDX_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             descend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic [IDX_W-1:0] count,
   output logic             frame_done
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic             desc_q, desc_d, desc_eff;
   logic             frame_done_q;
   logic             accept, last_beat, handshake, final_take, count_one;

   slot_t            new_slot;
   slot_t            slots [DEPTH];
   logic [DEPTH-1:0] prec;
   logic             unused_prec_top;

   assign accept     = in_valid & in_ready;
   assign count_one  = (count_q == IDX_W'(1));
   assign last_beat  = accept & (in_last | (count_q == IDX_W'(DEPTH - 1)));
   assign handshake  = out_valid & out_ready;
   assign final_take = handshake & count_one;
   // The first beat of a frame sorts against the live order select.
   assign desc_eff   = (count_q == '0) ? descend : desc_q;

   always_comb begin
      new_slot.valid = 1'b1;
      new_slot.data  = SLOT_DATA_W'(in_data);
      new_slot.index = SLOT_IDX_W'(count_q + 1'b1);
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic  lower_prec;
      slot_t lower_slot, upper_slot;

      if (i == 0) begin : g_bottom
         assign lower_prec = 1'b1;
         assign lower_slot = '0;
      end else begin : g_mid
         assign lower_prec = prec[i-1];
         assign lower_slot = slots[i-1];
      end

      if (i == DEPTH - 1) begin : g_top
         assign upper_slot = '0;
      end else begin : g_below
         assign upper_slot = slots[i+1];
      end

      sort_stream_cell #(
         .WIDTH(WIDTH)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .insert    (accept),
         .shift_down(handshake),
         .descend   (desc_eff),
         .new_slot  (new_slot),
         .lower_prec(lower_prec),
         .lower_slot(lower_slot),
         .upper_slot(upper_slot),
         .prec      (prec[i]),
         .slot      (slots[i])
      );
   end

   assign unused_prec_top = prec[DEPTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LOAD;
         count_q      <= '0;
         desc_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         desc_q       <= desc_d;
         frame_done_q <= final_take;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (last_beat)  state_d = DRAIN;
         DRAIN:   if (final_take) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      count_d = count_q;
      desc_d  = desc_q;
      if (accept) begin
         count_d = count_q + 1'b1;
         if (count_q == '0) desc_d = descend;
      end else if (handshake) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      in_ready  = (state_q == LOAD) & ~rst;
      out_valid = (state_q == DRAIN);
      out_last  = out_valid & count_one;
   end

   assign out_data   = slots[0].data[WIDTH-1:0];
   assign out_index  = slots[0].index[IDX_W-1:0];
   assign count      = count_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sort_stream.sv
// Directed bench for sort_stream (DEPTH=6) with an expected-output scoreboard.
module tb_sort_stream;

   localparam int unsigned DEPTH = 6;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned IDX_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_last, descend;
   logic [WIDTH-1:0] in_data;
   logic             out_valid, out_ready, out_last, frame_done;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_index, count;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [IDX_W-1:0] i;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] vals[$];
   int               n_cmp = 0;
   int               n_bad = 0;

   always #5 clk = ~clk;

   sort_stream #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .IDX_W(IDX_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .descend   (descend),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .count     (count),
      .frame_done(frame_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic [IDX_W-1:0] i);
      exp_t e;
      e.d = d;
      e.i = i;
      sb.push_back(e);
   endtask

   // Feed one beat per cycle; the frame must be in DRAIN on the following cycle.
   task automatic send(input logic [WIDTH-1:0] v[$], input bit use_last, input bit desc,
                       input bit toggle);
      foreach (v[k]) begin
         @(negedge clk);
         check("in_ready_load", 64'(in_ready), 64'd1);
         in_valid = 1'b1;
         in_data  = v[k];
         in_last  = use_last && (k == v.size() - 1);
         descend  = (toggle && (k % 2 == 1)) ? ~desc : desc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      check("drain_entry_valid", 64'(out_valid), 64'd1);
      check("drain_entry_ready", 64'(in_ready), 64'd0);
   endtask

   // mode 0: out_ready held high; mode 1: out_ready 1,0,1,0...
   task automatic drain(input int n, input int mode);
      int               got = 0;
      bit               stalled = 0;
      bit               r;
      logic [WIDTH-1:0] hd;
      logic [IDX_W-1:0] hi;
      exp_t             e;
      for (int k = 0; k < 4 * n + 8 && got < n; k++) begin
         @(negedge clk);
         if (stalled) begin
            check("stall_data", 64'(out_data), 64'(hd));
            check("stall_index", 64'(out_index), 64'(hi));
            stalled = 0;
         end
         r = (mode == 0) ? 1'b1 : (k % 2 == 0);
         out_ready = r;
         check("out_valid", 64'(out_valid), 64'd1);
         if (out_valid) begin
            check("count_drain", 64'(count), 64'(sb.size()));
            check("out_last", 64'(out_last), 64'(sb.size() == 1));
            if (r) begin
               if (sb.size() == 0) begin
                  check("extra_output", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("out_data", 64'(out_data), 64'(e.d));
                  check("out_index", 64'(out_index), 64'(e.i));
               end
               got++;
            end else begin
               hd      = out_data;
               hi      = out_index;
               stalled = 1;
            end
         end
      end
      if (got != n) check("drain_timeout", 64'(got), 64'(n));
      if (got == n && sb.size() == 0) begin
         @(negedge clk);
         out_ready = 1'b0;
         check("frame_done_pulse", 64'(frame_done), 64'd1);
         check("in_ready_after", 64'(in_ready), 64'd1);
         check("out_valid_after", 64'(out_valid), 64'd0);
         check("count_after", 64'(count), 64'd0);
         @(negedge clk);
         check("frame_done_single", 64'(frame_done), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      descend   = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_index", 64'(out_index), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Ascending, stable on the duplicate 3s.
      vals = '{32'd5, 32'd3, 32'd9, 32'd3, 32'd1};
      push(5, 1); push(9, 3);
      sb.delete();
      push(1, 5); push(3, 2); push(3, 4); push(5, 1); push(9, 3);
      send(vals, 1, 0, 0);
      check("count_loaded", 64'(count), 64'd5);
      drain(5, 0);

      // Descending.
      push(9, 3); push(5, 1); push(3, 2); push(3, 4); push(1, 5);
      send(vals, 1, 1, 0);
      drain(5, 0);

      // Descend toggled after the first beat is ignored (ascending frame).
      push(1, 5); push(3, 2); push(3, 4); push(5, 1); push(9, 3);
      send(vals, 1, 0, 1);
      drain(5, 0);

      // Descend toggled on a descending frame.
      push(9, 3); push(5, 1); push(3, 2); push(3, 4); push(1, 5);
      send(vals, 1, 1, 1);
      drain(5, 0);

      // DEPTH beats without in_last force DRAIN; a further beat is refused.
      vals = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
      push(2, 6); push(3, 5); push(4, 4); push(5, 3); push(6, 2); push(7, 1);
      send(vals, 0, 0, 0);
      in_valid = 1'b1;
      in_data  = 32'd99;
      @(negedge clk);
      check("forced_in_ready", 64'(in_ready), 64'd0);
      check("forced_count", 64'(count), 64'd6);
      in_valid = 1'b0;
      in_data  = '0;
      drain(6, 0);

      // Output backpressure on a six-sample frame.
      vals = '{32'd10, 32'd40, 32'd20, 32'd60, 32'd30, 32'd50};
      push(10, 1); push(20, 3); push(30, 5); push(40, 2); push(50, 6); push(60, 4);
      send(vals, 1, 0, 0);
      drain(6, 1);

      // Signedness of the key compare.
      vals = '{32'h0000_0001, 32'hFFFF_FFFF};
`ifdef SORT_STREAM_SIGNED_EN
      push(32'hFFFF_FFFF, 2); push(32'h0000_0001, 1);
`else
      push(32'h0000_0001, 1); push(32'hFFFF_FFFF, 2);
`endif
      send(vals, 1, 0, 0);
      drain(2, 0);

      // Reset in the middle of a drain discards the frame.
      vals = '{32'd4, 32'd8, 32'd2, 32'd6, 32'd1};
      push(1, 5); push(2, 3); push(4, 1); push(6, 4); push(8, 2);
      send(vals, 1, 0, 0);
      drain(2, 0);
      @(negedge clk);
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_release_ready", 64'(in_ready), 64'd1);
      check("midrst_release_valid", 64'(out_valid), 64'd0);

      vals = '{32'd8, 32'd2, 32'd5};
      push(2, 2); push(5, 3); push(8, 1);
      send(vals, 1, 0, 0);
      drain(3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
